// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI target with oversampled sclk/cs/sdi and single-byte host handshakes.
// Define SPI_SLAVE_OVERRUN_EN to keep unread bytes and flag a sticky receive overrun.
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    input  logic [7:0] din,
    input  logic       write,
    output logic       tx_ready,
    output logic [7:0] dout,
    output logic       rx_valid,
    input  logic       read,
    output logic       busy,
    output logic       overrun
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_s_q, cs_s_q, sdi_s_q;
    logic                   sclk_p_q, cs_p_q;
    logic                   sclk_sync, cs_sync, sdi_sync;
    logic                   sclk_r, sclk_f, cs_r, cs_f;

    logic [0:0] state_q, state_d;
    logic [7:0] tx_buf_q, tx_buf_d, shift_tx_q, shift_tx_d, dout_q, dout_d;
    logic [6:0] shift_rx_q, shift_rx_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
    logic       sdo_q, sdo_d, sdo_oe_q, sdo_oe_d, busy_q, busy_d;
    logic       in_shift, load, done;
    logic [7:0] tx_byte, rx_byte;

    assign sclk_sync = sclk_s_q[SYNC_STAGES-1];
    assign cs_sync   = cs_s_q[SYNC_STAGES-1];
    assign sdi_sync  = sdi_s_q[SYNC_STAGES-1];
    assign sclk_r    = sclk_sync & ~sclk_p_q;
    assign sclk_f    = ~sclk_sync & sclk_p_q;
    assign cs_r      = cs_sync & ~cs_p_q;
    assign cs_f      = ~cs_sync & cs_p_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sclk_s_q <= '0;
            cs_s_q   <= '1;
            sdi_s_q  <= '0;
            sclk_p_q <= 1'b0;
            cs_p_q   <= 1'b1;
        end else begin
            sclk_s_q <= {sclk_s_q[SYNC_STAGES-2:0], sclk};
            cs_s_q   <= {cs_s_q[SYNC_STAGES-2:0], cs};
            sdi_s_q  <= {sdi_s_q[SYNC_STAGES-2:0], sdi};
            sclk_p_q <= sclk_sync;
            cs_p_q   <= cs_sync;
        end
    end

    // A load point is frame start or the sclk fall that follows a completed byte.
    assign in_shift   = state_q == S_SHIFT;
    assign load       = (~in_shift & cs_f) | (in_shift & ~cs_r & sclk_f & (bit_cnt_q == 3'd0));
    assign done       = in_shift & ~cs_r & sclk_r & (bit_cnt_q == 3'd7);
    assign tx_byte    = tx_ready_q ? IDLE_BYTE : tx_buf_q;
    assign rx_byte    = {shift_rx_q, sdi_sync};
    assign tx_buf_d   = (write & tx_ready_q) ? din : tx_buf_q;
    assign tx_ready_d = (load & ~tx_ready_q) | (tx_ready_q & ~write);
    assign rx_valid_d = done | (rx_valid_q & ~read);

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun_q, overrun_d, drop;
    assign drop      = done & rx_valid_q & ~read;
    assign dout_d    = (done & ~drop) ? rx_byte : dout_q;
    assign overrun_d = drop | (overrun_q & ~read);
    assign overrun   = overrun_q;
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) overrun_q <= 1'b0;
        else       overrun_q <= overrun_d;
    end
`else
    assign dout_d  = done ? rx_byte : dout_q;
    assign overrun = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        shift_tx_d = shift_tx_q;
        shift_rx_d = shift_rx_q;
        bit_cnt_d  = bit_cnt_q;
        sdo_d      = sdo_q;
        sdo_oe_d   = sdo_oe_q;
        busy_d     = busy_q;
        if (load) begin
            shift_tx_d = tx_byte;
            sdo_d      = tx_byte[7];
            bit_cnt_d  = 3'd0;
            sdo_oe_d   = 1'b1;
            busy_d     = 1'b1;
            state_d    = S_SHIFT;
        end else if (in_shift) begin
            if (cs_r) begin
                sdo_oe_d  = 1'b0;
                sdo_d     = 1'b0;
                busy_d    = 1'b0;
                bit_cnt_d = 3'd0;
                state_d   = S_IDLE;
            end else if (sclk_r) begin
                shift_rx_d = rx_byte[6:0];
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end else if (sclk_f) begin
                sdo_d = shift_tx_q[~bit_cnt_q];
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tx_buf_q   <= 8'h00;
            shift_tx_q <= 8'h00;
            shift_rx_q <= 7'h00;
            bit_cnt_q  <= 3'd0;
            tx_ready_q <= 1'b1;
            rx_valid_q <= 1'b0;
            dout_q     <= 8'h00;
            sdo_q      <= 1'b0;
            sdo_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_buf_q   <= tx_buf_d;
            shift_tx_q <= shift_tx_d;
            shift_rx_q <= shift_rx_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            dout_q     <= dout_d;
            sdo_q      <= sdo_d;
            sdo_oe_q   <= sdo_oe_d;
            busy_q     <= busy_d;
        end
    end

    assign sdo      = sdo_q;
    assign sdo_oe   = sdo_oe_q;
    assign tx_ready = tx_ready_q;
    assign dout     = dout_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives spi_slave as a mode-0 SPI master at clk_in/8 and scoreboards
// the bytes seen on MISO and on the dout handshake.
module tb_spi_slave;
    logic       clk_in = 1'b0, reset = 1'b1, sclk = 1'b0, cs = 1'b1, sdi = 1'b0;
    logic       write = 1'b0, read = 1'b0;
    logic [7:0] din = 8'h00;
    logic       sdo, sdo_oe, tx_ready, rx_valid, busy, overrun;
    logic [7:0] dout, m;
    int         n_cmp = 0, n_err = 0;
    logic [7:0] exp_q[$], miso_q[$];

    typedef struct {
        logic       ld;
        logic [7:0] din;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_dout;
    } vec_t;
    vec_t vt[6];

    spi_slave dut (
        .clk_in(clk_in), .reset(reset), .sclk(sclk), .cs(cs), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .din(din), .write(write), .tx_ready(tx_ready),
        .dout(dout), .rx_valid(rx_valid), .read(read), .busy(busy), .overrun(overrun)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wr(input logic [7:0] d);
        din = d; write = 1'b1; cyc(1); write = 1'b0;
    endtask

    task automatic rd;
        read = 1'b1; cyc(1); read = 1'b0;
    endtask

    // Shifts n bits MSB-first; optionally issues two writes during the low phase of bit 5.
    task automatic bits(input logic [7:0] mosi, input int n, input logic mid,
                        input logic [7:0] w1, input logic [7:0] w2, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            sdi = mosi[i];
            if (mid && i == 5) begin
                wr(w1);
                chk("tx_ready_after_mid_write", {7'd0, tx_ready}, 8'd0);
                wr(w2);
                cyc(2);
            end else cyc(4);
            sclk = 1'b1;
            miso[i] = sdo;
            cyc(4);
            sclk = 1'b0;
        end
    endtask

    task automatic sb_check(input logic [7:0] miso);
        for (int i = 0; i < 10 && !rx_valid; i++) cyc(1);
        chk("rx_valid_set", {7'd0, rx_valid}, 8'd1);
        chk("dout", dout, exp_q.pop_front());
        chk("miso", miso, miso_q.pop_front());
    endtask

    task automatic cs_hi;
        cyc(4); cs = 1'b1; cyc(6);
    endtask

    task automatic frame1(input logic ld, input logic [7:0] d, input logic [7:0] mosi,
                          input logic [7:0] emiso, input logic [7:0] edout);
        if (ld) begin
            chk("tx_ready_before_write", {7'd0, tx_ready}, 8'd1);
            wr(d);
            chk("tx_ready_after_write", {7'd0, tx_ready}, 8'd0);
        end
        miso_q.push_back(emiso);
        exp_q.push_back(edout);
        cs = 1'b0;
        cyc(4);
        chk("busy_in_frame", {7'd0, busy}, 8'd1);
        chk("sdo_oe_in_frame", {7'd0, sdo_oe}, 8'd1);
        chk("tx_ready_after_cs_fall", {7'd0, tx_ready}, 8'd1);
        bits(mosi, 8, 1'b0, 8'h00, 8'h00, m);
        sb_check(m);
        cs_hi();
        chk("busy_after_frame", {7'd0, busy}, 8'd0);
        rd();
        chk("rx_valid_after_read", {7'd0, rx_valid}, 8'd0);
    endtask

    initial begin
        vt[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vt[1] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
        vt[2] = '{1'b0, 8'h5A, 8'hC3, 8'h00, 8'hC3};
        vt[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80};
        vt[4] = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h01};
        vt[5] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};

        cyc(2);
        chk("rst_sdo", {7'd0, sdo}, 8'd0);
        chk("rst_sdo_oe", {7'd0, sdo_oe}, 8'd0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_rx_valid", {7'd0, rx_valid}, 8'd0);
        chk("rst_tx_ready", {7'd0, tx_ready}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_overrun", {7'd0, overrun}, 8'd0);
        reset = 1'b0;
        cyc(3);

        for (int k = 0; k < 6; k++) frame1(vt[k].ld, vt[k].din, vt[k].mosi, vt[k].exp_miso, vt[k].exp_dout);

        // Asynchronous reset in the middle of a frame with a byte pending.
        wr(8'h77);
        cs = 1'b0;
        cyc(4);
        bits(8'hC3, 4, 1'b0, 8'h00, 8'h00, m);
        #2 reset = 1'b1; cs = 1'b1;
        #1;
        chk("midrst_busy", {7'd0, busy}, 8'd0);
        chk("midrst_sdo_oe", {7'd0, sdo_oe}, 8'd0);
        chk("midrst_tx_ready", {7'd0, tx_ready}, 8'd1);
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_sdo", {7'd0, sdo}, 8'd0);
        cyc(2);
        reset = 1'b0;
        cyc(2);
        frame1(1'b0, 8'h00, 8'h96, 8'h00, 8'h96);

        // Two-byte frame with idle fill, read after each byte.
        cs = 1'b0;
        cyc(4);
        miso_q.push_back(8'h00); exp_q.push_back(8'h81);
        bits(8'h81, 8, 1'b0, 8'h00, 8'h00, m);
        sb_check(m);
        rd();
        chk("rx_valid_cleared_mid_frame", {7'd0, rx_valid}, 8'd0);
        miso_q.push_back(8'h00); exp_q.push_back(8'h7E);
        bits(8'h7E, 8, 1'b0, 8'h00, 8'h00, m);
        sb_check(m);
        cs_hi();
        rd();

        // Reload mid-byte; a write while the buffer is full must be ignored.
        wr(8'h11);
        cs = 1'b0;
        cyc(4);
        miso_q.push_back(8'h11); exp_q.push_back(8'hE7);
        bits(8'hE7, 8, 1'b1, 8'h22, 8'h33, m);
        sb_check(m);
        rd();
        miso_q.push_back(8'h22); exp_q.push_back(8'h18);
        bits(8'h18, 8, 1'b0, 8'h00, 8'h00, m);
        sb_check(m);
        cs_hi();
        rd();
        chk("tx_ready_after_reload_frame", {7'd0, tx_ready}, 8'd1);
        frame1(1'b0, 8'h00, 8'h42, 8'h00, 8'h42);

        // Abort after 5 bits.
        cs = 1'b0;
        cyc(4);
        bits(8'hF0, 5, 1'b0, 8'h00, 8'h00, m);
        cs_hi();
        chk("abort_rx_valid", {7'd0, rx_valid}, 8'd0);
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_sdo_oe", {7'd0, sdo_oe}, 8'd0);
        chk("abort_sdo", {7'd0, sdo}, 8'd0);
        frame1(1'b0, 8'h00, 8'h0F, 8'h00, 8'h0F);

        // Two bytes without read.
        cs = 1'b0;
        cyc(4);
        bits(8'h01, 8, 1'b0, 8'h00, 8'h00, m);
        bits(8'h02, 8, 1'b0, 8'h00, 8'h00, m);
        cs_hi();
        chk("ovr_rx_valid", {7'd0, rx_valid}, 8'd1);
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("ovr_dout", dout, 8'h01);
        chk("ovr_flag", {7'd0, overrun}, 8'd1);
`else
        chk("ovr_dout", dout, 8'h02);
        chk("ovr_flag", {7'd0, overrun}, 8'd0);
`endif
        rd();
        chk("ovr_rx_valid_cleared", {7'd0, rx_valid}, 8'd0);
        chk("ovr_flag_cleared", {7'd0, overrun}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral-side (target) endpoint: the receiving end of the codebase's SPI controller link, for boards where this FPGA is driven by an external SPI master.
- Mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit words, multi-byte frames while cs stays low.
- External sclk/cs/sdi are oversampled in the clk_in domain; the host side uses single-byte read/write handshakes matching the controller block's style.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sclk, cs and sdi (minimum 2).
- IDLE_BYTE, 8'h00, byte shifted out when no transmit byte is loaded at a byte boundary.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from external master.
- cs  input  1  chip select from master, active low.
- sdi  input  1  MOSI serial data in.
- sdo  output  1  MISO serial data out.
- sdo_oe  output  1  MISO drive enable (1 while frame active).
- din  input  8  byte to transmit.
- write  input  1  load din into transmit buffer.
- tx_ready  output  1  transmit buffer empty, write accepted.
- dout  output  8  last received byte.
- rx_valid  output  1  dout holds an unread byte.
- read  input  1  acknowledge dout, clears rx_valid.
- busy  output  1  frame in progress (cs low).
- overrun  output  1  receive overrun flag (optional feature).

Behaviour:
- Reset: asynchronous, all state cleared immediately.
  - Reset values: sdo=0, sdo_oe=0, dout=0, rx_valid=0, tx_ready=1, busy=0, overrun=0, state=S_IDLE.
  - Synchronizer reset values: cs stages 1, sclk stages 0, sdi stages 0.
- Synchronizers: each of sclk/cs/sdi passes through SYNC_STAGES flops. sclk_r/sclk_f = rise/fall detected from last stage vs one-cycle delayed copy; cs_f/cs_r likewise.
  - Requirement on master: sclk high and low phases each ≥ SYNC_STAGES+2 clk_in periods.
  - Requirement on master: cs low ≥ SYNC_STAGES+2 clk_in periods before the first sclk rise.
- Transmit buffer:
  - write with tx_ready=1: tx_buf<=din, tx_ready<=0.
  - write with tx_ready=0: ignored.
  - Consumption at a load point sets tx_ready<=1.
  - Consume and write in the same cycle with tx_ready=0: old byte consumed, write ignored.
  - Consume and write in the same cycle with tx_ready=1: IDLE_BYTE shifted, din stored.
- FSM S_IDLE:
  - busy=0, sdo_oe=0.
  - On cs_f, a load point occurs:
    - shift_tx <= tx_buf if loaded, else IDLE_BYTE.
    - sdo <= that byte's bit 7.
    - bit_cnt <= 0, sdo_oe <= 1, busy <= 1.
    - Next state: S_SHIFT.
- FSM S_SHIFT, on sclk_r:
  - shift_rx <= {shift_rx[6:0], sdi_sync}; bit_cnt <= bit_cnt+1 (3-bit, wraps 7→0).
  - When bit_cnt was 7: dout <= {shift_rx[6:0], sdi_sync}, rx_valid <= 1.
- FSM S_SHIFT, on sclk_f:
  - bit_cnt==0 (byte boundary): new load point as above, MSB of next byte driven.
  - Otherwise: sdo <= shift_tx[7-bit_cnt].
- FSM S_SHIFT, on cs_r (any time): abort.
  - Partial byte discarded, no rx_valid.
  - sdo_oe<=0, sdo<=0, busy<=0, bit_cnt<=0.
  - Next state: S_IDLE.
  - tx_buf is untouched unless already consumed.
- Latency:
  - dout/rx_valid update on the clk_in edge after the synchronized 8th sclk rise is detected.
  - sdo updates on the clk_in edge after the synchronized sclk fall is detected.
- rx_valid is a level; read clears it on the next edge.
  - read with rx_valid=0: no effect.
  - Byte completion and read in the same cycle: rx_valid stays 1 with new data.
- sclk edges while state=S_IDLE are ignored.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- Defined:
  - If a byte completes while rx_valid=1 and read is not asserted in that cycle, dout keeps the old byte, the new byte is dropped, and overrun<=1.
  - overrun is sticky; cleared by read.
- Undefined:
  - A completed byte always overwrites dout; overrun tied 0.

Test Plan:
- Reset mid-frame after 4 sclk rises → outputs at reset values immediately; next full frame receives correctly.
- write din=8'hA5, cs low, master sends 8'h3C at sclk = clk_in/8 → master reads 8'hA5 on sdo; dout=8'h3C, rx_valid=1, tx_ready=1 after cs_f.
- No write, 2-byte frame master sends 8'h81, 8'h7E, read pulsed after each byte → sdo shifts 8'h00 twice; dout sequence 8'h81 then 8'h7E.
- Load 8'h11, frame byte 1; load 8'h22 mid-byte 1; write 8'h33 while tx_ready=0 → sdo bytes 8'h11, 8'h22; 8'h33 ignored.
- cs raised after 5 bits of 8'hF0 → no rx_valid, busy=0, sdo_oe=0; next frame 8'h0F → dout=8'h0F.
- Two bytes 8'h01, 8'h02 without read → macro on: dout=8'h01, overrun=1, read clears both; macro off: dout=8'h02, overrun=0.
